// File: rtl/branch_predictor_2bc.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational; updates, flush and the mispredict statistic are registered.
module branch_predictor_2bc #(
   parameter int ENTRIES   = 16,
   parameter int TAG_BITS  = 8,
   parameter int CTR_BITS  = 2,
   parameter int STAT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 lookup_valid,
   input  logic [31:0]          lookup_pc,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic                 upd_taken,
   input  logic [31:0]          upd_target,
   input  logic                 upd_mispredict,
   input  logic                 flush,
   output logic                 pred_hit,
   output logic                 pred_taken,
   output logic [31:0]          pred_target,
   output logic [STAT_BITS-1:0] mispredict_count
);

   localparam int IDX = $clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
   localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

   logic [ENTRIES-1:0]                valid_q;
   logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q;
   logic [ENTRIES-1:0][CTR_BITS-1:0]  ctr_q;
   logic [ENTRIES-1:0][31:0]          tgt_q;
   logic [STAT_BITS-1:0]              stat_q, stat_d;

   logic [IDX-1:0]      lk_idx, up_idx;
   logic [TAG_BITS-1:0] lk_tag, up_tag;
   logic                lk_match, up_hit, up_alloc, up_wr_tgt;
   logic [CTR_BITS-1:0] ctr_d;

   assign lk_idx = lookup_pc[IDX+1:2];
   assign lk_tag = lookup_pc[IDX+TAG_BITS+1:IDX+2];
   assign up_idx = upd_pc[IDX+1:2];
   assign up_tag = upd_pc[IDX+TAG_BITS+1:IDX+2];

   // Outputs are forced low while reset is held, independent of table contents.
   assign lk_match    = lookup_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag) & ~reset;
   assign pred_hit    = lk_match;
   assign pred_taken  = lk_match & ctr_q[lk_idx][CTR_BITS-1];
   assign pred_target = lk_match ? tgt_q[lk_idx] : 32'd0;

   assign up_hit    = upd_valid & valid_q[up_idx] & (tag_q[up_idx] == up_tag);
   assign up_alloc  = upd_valid & ~up_hit & upd_taken;
   assign up_wr_tgt = ~flush & (up_alloc | (up_hit & upd_taken));

   always_comb begin
      ctr_d = ctr_q[up_idx];
      if (up_alloc)
         ctr_d = CTR_WEAK;
      else if (up_hit && upd_taken && ctr_q[up_idx] != CTR_MAX)
         ctr_d = ctr_q[up_idx] + CTR_BITS'(1);
      else if (up_hit && !upd_taken && ctr_q[up_idx] != '0)
         ctr_d = ctr_q[up_idx] - CTR_BITS'(1);
   end

   always_comb begin
      stat_d = stat_q;
      if (upd_valid && upd_mispredict && stat_q != STAT_MAX)
         stat_d = stat_q + STAT_BITS'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         ctr_q   <= '0;
         stat_q  <= '0;
      end else begin
         stat_q <= stat_d;
         if (flush) begin
            valid_q <= '0;
         end else if (up_hit || up_alloc) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= ctr_d;
         end
      end
   end

   // Tags and targets carry no reset; they are only meaningful behind a valid bit.
   always_ff @(posedge clk) begin
      if (!reset && up_wr_tgt) begin
         tgt_q[up_idx] <= upd_target;
         if (up_alloc)
            tag_q[up_idx] <= up_tag;
      end
   end

   assign mispredict_count = stat_q;

endmodule

// File: tb/tb_branch_predictor_2bc.sv
// Directed bench: default-parameter predictor plus a STAT_BITS=4 instance for saturation.
module tb_branch_predictor_2bc;

   logic        clk = 1'b0;
   logic        reset, lookup_valid, upd_valid, upd_taken, upd_mispredict, flush;
   logic [31:0] lookup_pc, upd_pc, upd_target;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic [15:0] mispredict_count;

   logic        reset2, upd_valid2, upd_mispredict2;
   logic        pred_hit2, pred_taken2;
   logic [31:0] pred_target2;
   logic [3:0]  mispredict_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_predictor_2bc dut (
      .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .mispredict_count(mispredict_count)
   );

   branch_predictor_2bc #(.STAT_BITS(4)) dut2 (
      .clk(clk), .reset(reset2), .lookup_valid(1'b0), .lookup_pc(32'd0),
      .upd_valid(upd_valid2), .upd_pc(32'd0), .upd_taken(1'b0),
      .upd_target(32'd0), .upd_mispredict(upd_mispredict2), .flush(1'b0),
      .pred_hit(pred_hit2), .pred_taken(pred_taken2), .pred_target(pred_target2),
      .mispredict_count(mispredict_count2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pred(input string tag, input logic [31:0] pc,
                       input logic h, input logic t, input logic [31:0] tgt);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      #1;
      check({tag, ".hit"},    {31'd0, pred_hit},   {31'd0, h});
      check({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, t});
      check({tag, ".target"}, pred_target,         tgt);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic mis);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
      step();
      upd_valid = 1'b0; upd_mispredict = 1'b0;
   endtask

   initial begin
      reset = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h100;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      upd_mispredict = 1'b0; flush = 1'b0;
      reset2 = 1'b1; upd_valid2 = 1'b0; upd_mispredict2 = 1'b0;

      #2;
      pred("in_reset", 32'h100, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b0; reset2 = 1'b0;
      pred("post_reset", 32'h100, 1'b0, 1'b0, 32'h0);
      check("post_reset.count", 32'(mispredict_count), 32'd0);

      // allocate; same-cycle lookup must see the old (empty) entry
      upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h140;
      pred("same_cycle", 32'h100, 1'b0, 1'b0, 32'h0);
      step();
      upd_valid = 1'b0;
      pred("alloc", 32'h100, 1'b1, 1'b1, 32'h140);

      // counter walk 2->1->0->0, target kept on not-taken
      upd(32'h100, 1'b0, 32'h999, 1'b0);
      pred("ctr1", 32'h100, 1'b1, 1'b0, 32'h140);
      upd(32'h100, 1'b0, 32'h999, 1'b0);
      pred("ctr0", 32'h100, 1'b1, 1'b0, 32'h140);
      upd(32'h100, 1'b0, 32'h999, 1'b0);
      pred("ctr0_sat", 32'h100, 1'b1, 1'b0, 32'h140);
      // 0->1->2->3->3, taken update overwrites target
      upd(32'h100, 1'b1, 32'h180, 1'b0);
      pred("ctr1_up", 32'h100, 1'b1, 1'b0, 32'h180);
      upd(32'h100, 1'b1, 32'h180, 1'b0);
      pred("ctr2_up", 32'h100, 1'b1, 1'b1, 32'h180);
      upd(32'h100, 1'b1, 32'h180, 1'b0);
      upd(32'h100, 1'b1, 32'h180, 1'b0);
      pred("ctr3_sat", 32'h100, 1'b1, 1'b1, 32'h180);
      // from saturated 3 one not-taken gives 2 (still taken); a wrap would give 0
      upd(32'h100, 1'b0, 32'h999, 1'b0);
      pred("ctr3_dec", 32'h100, 1'b1, 1'b1, 32'h180);

      // aliasing at same index, different tag
      pred("alias_miss", 32'h140, 1'b0, 1'b0, 32'h0);
      upd(32'h140, 1'b1, 32'h300, 1'b0);
      pred("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
      pred("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);
      // not-taken misses leave the table alone
      upd(32'h100, 1'b0, 32'h444, 1'b0);
      pred("nt_miss_a", 32'h140, 1'b1, 1'b1, 32'h300);
      pred("nt_miss_b", 32'h100, 1'b0, 1'b0, 32'h0);
      upd(32'h104, 1'b0, 32'h444, 1'b0);
      pred("nt_miss_c", 32'h104, 1'b0, 1'b0, 32'h0);

      // mispredict statistic, and qualification by upd_valid
      upd(32'h104, 1'b0, 32'h0, 1'b1);
      check("stat_inc", 32'(mispredict_count), 32'd1);
      upd_mispredict = 1'b1;
      step();
      upd_mispredict = 1'b0;
      check("stat_unqual", 32'(mispredict_count), 32'd1);

      // flush beats a simultaneous allocate
      flush = 1'b1;
      upd(32'h200, 1'b1, 32'h500, 1'b0);
      flush = 1'b0;
      pred("flush_100", 32'h100, 1'b0, 1'b0, 32'h0);
      pred("flush_200", 32'h200, 1'b0, 1'b0, 32'h0);
      pred("flush_140", 32'h140, 1'b0, 1'b0, 32'h0);
      check("flush_stat", 32'(mispredict_count), 32'd1);

      // reset mid-operation with a pending update
      upd(32'h100, 1'b1, 32'h140, 1'b0);
      pred("pre_rst", 32'h100, 1'b1, 1'b1, 32'h140);
      upd_valid = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1; upd_target = 32'h700;
      reset = 1'b1;
      pred("rst_async", 32'h100, 1'b0, 1'b0, 32'h0);
      check("rst_async.count", 32'(mispredict_count), 32'd0);
      step();
      upd_valid = 1'b0;
      reset = 1'b0;
      pred("rst_100", 32'h100, 1'b0, 1'b0, 32'h0);
      pred("rst_104", 32'h104, 1'b0, 1'b0, 32'h0);

      // narrow statistic saturates at 15
      upd_valid2 = 1'b1; upd_mispredict2 = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("stat4_10", 32'(mispredict_count2), 32'd10);
      for (int i = 0; i < 10; i++) step();
      check("stat4_sat", 32'(mispredict_count2), 32'd15);
      #2;
      reset2 = 1'b1;
      #1;
      check("stat4_async_rst", 32'(mispredict_count2), 32'd0);
      upd_valid2 = 1'b0; upd_mispredict2 = 1'b0;
      step();
      reset2 = 1'b0;
      step();
      check("stat4_after_rst", 32'(mispredict_count2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
